// File: rtl/ssd_pkg.sv
// Shared symbol codes, segment patterns and types for the seven-segment scan driver.
package ssd_pkg;

  localparam int unsigned CODE_W     = 5;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;

  // Symbol codes beyond the plain hex digits 0-9, A, b, F
  localparam logic [CODE_W-1:0] SYM_C     = 5'd12;
  localparam logic [CODE_W-1:0] SYM_D     = 5'd13;
  localparam logic [CODE_W-1:0] SYM_E     = 5'd14;
  localparam logic [CODE_W-1:0] SYM_L     = 5'd16;
  localparam logic [CODE_W-1:0] SYM_DASH  = 5'd17;
  localparam logic [CODE_W-1:0] SYM_BLANK = 5'd18;
  localparam logic [CODE_W-1:0] SYM_P     = 5'd19;
  localparam logic [CODE_W-1:0] SYM_N     = 5'd20;
  localparam logic [CODE_W-1:0] SYM_H     = 5'd21;
  localparam logic [CODE_W-1:0] SYM_U     = 5'd22;
  localparam logic [CODE_W-1:0] SYM_T     = 5'd23;

  // Active-low segment patterns, {a,b,c,d,e,f,g} on [6:0]
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_L     = 7'b1110001;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_P     = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_N     = 7'b1101010;
  localparam logic [SEG_W-1:0] SEG_H     = 7'b1001000;
  localparam logic [SEG_W-1:0] SEG_U     = 7'b1000001;
  localparam logic [SEG_W-1:0] SEG_T     = 7'b1110000;

  // Digit currently being scanned; scan order is 3 -> 2 -> 1 -> 0
  typedef enum logic [1:0] {
    DIG_0 = 2'd0,
    DIG_1 = 2'd1,
    DIG_2 = 2'd2,
    DIG_3 = 2'd3
  } digit_e;

  // One latched display frame: per-digit codes plus blink enables
  typedef struct packed {
    logic [NUM_DIGITS-1:0]             mask;
    logic [NUM_DIGITS-1:0][CODE_W-1:0] code;
  } frame_t;

endpackage

// File: rtl/ssd_decoder.sv
// Combinational 5-bit symbol code to active-low seven-segment pattern.
module ssd_decoder
  import ssd_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg
);

  // Symbol table lookup; unused codes render blank
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:     seg = SEG_0;
      5'd1:     seg = SEG_1;
      5'd2:     seg = SEG_2;
      5'd3:     seg = SEG_3;
      5'd4:     seg = SEG_4;
      5'd5:     seg = SEG_5;
      5'd6:     seg = SEG_6;
      5'd7:     seg = SEG_7;
      5'd8:     seg = SEG_8;
      5'd9:     seg = SEG_9;
      5'd10:    seg = SEG_A;
      5'd11:    seg = SEG_B;
      SYM_C:    seg = SEG_C;
      SYM_D:    seg = SEG_D;
      SYM_E:    seg = SEG_E;
      5'd15:    seg = SEG_F;
      SYM_L:    seg = SEG_L;
      SYM_DASH: seg = SEG_DASH;
      SYM_P:    seg = SEG_P;
      SYM_N:    seg = SEG_N;
      SYM_H:    seg = SEG_H;
      SYM_U:    seg = SEG_U;
      SYM_T:    seg = SEG_T;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-frame input latching and digit blink.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_DIGITS*CODE_W-1:0] ssd_code,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  output logic [NUM_DIGITS-1:0]        AN,
  output logic [SEG_W-1:0]             seven_out
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [REF_W-1:0]  refresh_cnt;
  logic [BLK_W-1:0]  blink_cnt;
  logic              blink_phase;
  digit_e            digit_q, digit_d;
  frame_t            shadow;
  logic              ref_wrap_c, blk_wrap_c, frame_start_c;

  // Pipeline stage 1: counter state delayed so it lines up with the latched frame
  logic              s1_vld;
  digit_e            s1_digit;
  logic              s1_phase;

  logic [CODE_W-1:0] sel_code_c;
  logic [SEG_W-1:0]  dec_seg_c;
  logic              blank_c;

  assign ref_wrap_c    = (refresh_cnt == REF_LAST);
  assign blk_wrap_c    = (blink_cnt == BLK_LAST);
  assign frame_start_c = (digit_q == DIG_3) && (refresh_cnt == '0);

  // Per-digit dwell counter
  always_ff @(posedge clk) begin
    if (rst)             refresh_cnt <= '0;
    else if (ref_wrap_c) refresh_cnt <= '0;
    else                 refresh_cnt <= refresh_cnt + 1'b1;
  end

  // Free-running blink half-period counter and phase
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blk_wrap_c) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Scan FSM state register
  always_ff @(posedge clk) begin
    if (rst) digit_q <= DIG_3;
    else     digit_q <= digit_d;
  end

  // Scan FSM next state: step to the next digit on each dwell wrap
  always_comb begin
    digit_d = digit_q;
    if (ref_wrap_c) begin
      case (digit_q)
        DIG_3:   digit_d = DIG_2;
        DIG_2:   digit_d = DIG_1;
        DIG_1:   digit_d = DIG_0;
        default: digit_d = DIG_3;
      endcase
    end
  end

  // Latch a whole frame of inputs at frame start so no digit mixes two frames
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow.mask <= '0;
      shadow.code <= {NUM_DIGITS{SYM_BLANK}};
    end else if (frame_start_c) begin
      shadow.mask <= blink_mask;
      shadow.code <= ssd_code;
    end
  end

  // Stage 1 register; s1_vld keeps the pins dark until the first post-reset digit
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_digit <= DIG_3;
      s1_phase <= 1'b0;
    end else begin
      s1_vld   <= 1'b1;
      s1_digit <= digit_q;
      s1_phase <= blink_phase;
    end
  end

  assign sel_code_c = shadow.code[2'(s1_digit)];
  assign blank_c    = !s1_vld || (s1_phase && shadow.mask[2'(s1_digit)]);

  ssd_decoder u_decoder (
    .code (sel_code_c),
    .seg  (dec_seg_c)
  );

  // Output registers: one anode low at most, segments from the latched frame
  always_ff @(posedge clk) begin
    if (rst || blank_c) begin
      AN        <= '1;
      seven_out <= SEG_BLANK;
    end else begin
      AN        <= ~(NUM_DIGITS'(1) << 2'(s1_digit));
      seven_out <= dec_seg_c;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: frame/cycle arithmetic model feeds an expectation queue.
module tb_ssd_scan_driver;

  localparam int RD    = 4;
  localparam int BD    = 16;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ssd_code;
  logic [3:0]  blink_mask;
  logic [3:0]  AN;
  logic [6:0]  seven_out;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];
  logic [23:0] cap[int];
  int          k       = 0;
  bit          started = 1'b0;

  ssd_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .ssd_code   (ssd_code),
    .blink_mask (blink_mask),
    .AN         (AN),
    .seven_out  (seven_out)
  );

  always #5 clk = ~clk;

  // Glyphs described by their lit segment letters; converted to active-low {a..g}
  function automatic logic [6:0] glyph(input int c);
    string s;
    logic [6:0] p;
    case (c)
      0: s = "abcdef";   1: s = "bc";      2: s = "abdeg";   3: s = "abcdg";
      4: s = "bcfg";     5: s = "acdfg";   6: s = "acdefg";  7: s = "abc";
      8: s = "abcdefg";  9: s = "abcdfg";  10: s = "abcefg"; 11: s = "cdefg";
      12: s = "adef";    13: s = "bcdeg";  14: s = "adefg";  15: s = "aefg";
      16: s = "def";     17: s = "g";      19: s = "abefg";  20: s = "ceg";
      21: s = "bcefg";   22: s = "bcdef";  23: s = "defg";
      default: s = "";
    endcase
    p = 7'h7F;
    for (int i = 0; i < s.len(); i++) p[6 - (int'(s[i]) - 97)] = 1'b0;
    return p;
  endfunction

  // Expected pins for the counter state of cycle m (m counted from reset release)
  function automatic logic [10:0] model(input int m, input logic [23:0] fr);
    int dig;
    int code;
    bit phase;
    dig   = 3 - ((m / RD) % 4);
    phase = ((m / BD) % 2) == 1;
    code  = int'((fr[19:0] >> (5 * dig)) & 20'h1F);
    if (phase && fr[20 + dig]) return {4'hF, 7'h7F};
    return {~(4'b0001 << dig), glyph(code)};
  endfunction

  // Reference model: tracks cycles since reset, frame captures, and pushes each edge's expected pins
  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      k = 0;
      cap.delete();
      exp_q.push_back({4'hF, 7'h7F});
    end else if (started) begin
      if (k % FRAME == 0) cap[k / FRAME] = {blink_mask, ssd_code};
      if (k == 0) exp_q.push_back({4'hF, 7'h7F});
      else        exp_q.push_back(model(k - 1, cap[(k - 1) / FRAME]));
      k++;
    end
  end

  // Monitor: compare pins to the queued expectation away from the active edge
  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (AN !== e[10:7]) begin
        failures++;
        $display("FAIL an k=%0d got=%b exp=%b", k, AN, e[10:7]);
      end
      checks++;
      if (seven_out !== e[6:0]) begin
        failures++;
        $display("FAIL seg k=%0d got=%b exp=%b an=%b", k, seven_out, e[6:0], AN);
      end
    end
    if (started) begin
      checks++;
      if ($countones(~AN) > 1 || $isunknown(AN)) begin
        failures++;
        $display("FAIL an_onehot k=%0d got=%b exp=at_most_one_low", k, AN);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    ssd_code   = '0;
    blink_mask = '0;
    step(2);

    // {C,L,5,d}, no blink, two full frames
    do_reset();
    ssd_code   = {5'd12, 5'd16, 5'd5, 5'd13};
    blink_mask = 4'b0000;
    step(2 * FRAME + 4);

    // {0,1,dash,blank} then a change while digit 1 is scanning
    do_reset();
    ssd_code = {5'd0, 5'd1, 5'd17, 5'd18};
    step(9);
    ssd_code = {5'd8, 5'd21, 5'd19, 5'd23};
    step(FRAME + 6);

    // Blink on digit 3 only
    do_reset();
    blink_mask = 4'b1000;
    ssd_code   = {5'd0, 5'd18, 5'd18, 5'd18};
    step(5 * BD);

    // Reset pulse while digit 1 is scanning
    do_reset();
    blink_mask = 4'b0000;
    ssd_code   = {5'd20, 5'd22, 5'd14, 5'd15};
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(FRAME + 4);

    // Random codes, masks and occasional resets
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) ssd_code = 20'($urandom);
      if ($urandom_range(15) == 0) blink_mask = 4'($urandom);
      rst = ($urandom_range(999) == 0);
      step(1);
    end
    rst = 1'b0;
    step(4);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() > 1) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=<=1", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
